ptw_axi_reader: RTL and testbench

Shared page-table-walk read engine between the instruction/data TLBs and the AXI4 read channel of the memory interconnect. Each TLB issues a one-cycle PTE-fetch pulse with an 8-byte-aligned physical address and expects a one-cycle data-valid pulse carrying the 64-bit PTE. This block latches both requesters, arbitrates round-robin, and runs one single-beat AXI read at a time. It returns the PTE, or an error indication that the TLB turns into an access fault.

---
 rtl/ptw_axi_pkg.sv | 20 ++
 rtl/ptw_req_slot.sv | 38 +++
 rtl/ptw_axi_reader.sv | 186 ++++++++++++++++++
 tb/tb_ptw_axi_reader.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_axi_pkg.sv
// rtl/ptw_axi_pkg.sv - shared types and AXI constants for the page-table-walk reader
package ptw_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } ptw_state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [2:0] SIZE_8B      = 3'd3;
  localparam logic [2:0] ARPROT_VAL   = 3'b001;
  localparam logic [3:0] ARCACHE_VAL  = 4'b0011;
  localparam logic [7:0] ARLEN_SINGLE = 8'd0;

  localparam logic ITLB = 1'b0;
  localparam logic DTLB = 1'b1;

endpackage

// File: rtl/ptw_req_slot.sv
// rtl/ptw_req_slot.sv - one-deep pending request slot for a single TLB port
module ptw_req_slot #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_addr_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_kill,
  input  logic                  i_busy,
  input  logic                  i_grant,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_accept;

  // A kill frees the port, so a pulse in the same cycle is taken even if a request was pending.
  assign w_accept = i_addr_valid && (i_kill || (!r_valid && !i_busy));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr & ~ADDR_WIDTH'(7);
    end else if (i_kill || i_grant) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;

endmodule

// File: rtl/ptw_axi_reader.sv
// rtl/ptw_axi_reader.sv - round-robin PTE fetch engine for ITLB/DTLB over a single-beat AXI read
module ptw_axi_reader
  import ptw_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int PA_WIDTH   = 56,
  parameter int ID_WIDTH   = 4,
  parameter int ITLB_ID    = 0,
  parameter int DTLB_ID    = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  ITLB_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] ITLB_ADDR,
  input  logic                  ITLB_KILL,
  output logic                  ITLB_DATA_VALID,
  output logic [DATA_WIDTH-1:0] ITLB_DATA,
  output logic                  ITLB_ERROR,
  input  logic                  DTLB_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] DTLB_ADDR,
  input  logic                  DTLB_KILL,
  output logic                  DTLB_DATA_VALID,
  output logic [DATA_WIDTH-1:0] DTLB_DATA,
  output logic                  DTLB_ERROR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [ID_WIDTH-1:0]   M_ARID,
  output logic [7:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  output logic [2:0]            M_ARPROT,
  output logic [3:0]            M_ARCACHE,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [ID_WIDTH-1:0]   M_RID,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST
);

  ptw_state_e            r_state;
  logic                  r_port;
  logic                  r_rr_last;
  logic                  r_kill_inflight;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [ID_WIDTH-1:0]   r_arid;
  logic                  r_i_dv, r_i_err, r_d_dv, r_d_err;
  logic [DATA_WIDTH-1:0] r_i_data, r_d_data;

  logic                  w_i_valid, w_d_valid;
  logic [ADDR_WIDTH-1:0] w_i_addr, w_d_addr;
  logic                  w_i_req, w_d_req, w_any, w_pick;
  logic                  w_i_grant, w_d_grant, w_i_busy, w_d_busy;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [ID_WIDTH-1:0]   w_gnt_id;
  logic                  w_addr_bad, w_port_kill, w_drop, w_rsp_err;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_itlb_slot (
    .i_clk(CLK), .i_rstn(RSTN), .i_addr_valid(ITLB_ADDR_VALID), .i_addr(ITLB_ADDR),
    .i_kill(ITLB_KILL), .i_busy(w_i_busy), .i_grant(w_i_grant),
    .o_valid(w_i_valid), .o_addr(w_i_addr)
  );

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_dtlb_slot (
    .i_clk(CLK), .i_rstn(RSTN), .i_addr_valid(DTLB_ADDR_VALID), .i_addr(DTLB_ADDR),
    .i_kill(DTLB_KILL), .i_busy(w_d_busy), .i_grant(w_d_grant),
    .o_valid(w_d_valid), .o_addr(w_d_addr)
  );

  // A slot being killed this cycle is not eligible for grant.
  assign w_i_req    = w_i_valid && !ITLB_KILL;
  assign w_d_req    = w_d_valid && !DTLB_KILL;
  assign w_any      = w_i_req || w_d_req;
  // Round-robin pointer only moves on contention: both pending -> the loser of the last contest wins.
  assign w_pick     = (w_i_req && w_d_req) ? ~r_rr_last : w_d_req;
  assign w_i_grant  = (r_state == IDLE) && w_any && (w_pick == ITLB);
  assign w_d_grant  = (r_state == IDLE) && w_any && (w_pick == DTLB);
  assign w_i_busy   = (r_state != IDLE) && (r_port == ITLB);
  assign w_d_busy   = (r_state != IDLE) && (r_port == DTLB);
  assign w_gnt_addr = w_pick ? w_d_addr : w_i_addr;
  assign w_gnt_id   = w_pick ? ID_WIDTH'(DTLB_ID) : ID_WIDTH'(ITLB_ID);
  assign w_addr_bad = |w_gnt_addr[ADDR_WIDTH-1:PA_WIDTH];

  assign w_port_kill = r_port ? DTLB_KILL : ITLB_KILL;
  assign w_drop      = r_kill_inflight || w_port_kill;
  assign w_rsp_err   = (M_RRESP != RESP_OKAY) || (M_RID != r_arid) || !M_RLAST;
  assign w_rsp_data  = w_rsp_err ? '0 : M_RDATA;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state         <= IDLE;
      r_port          <= ITLB;
      r_rr_last       <= DTLB;
      r_kill_inflight <= 1'b0;
      r_arvalid       <= 1'b0;
      r_rready        <= 1'b0;
      r_araddr        <= '0;
      r_arid          <= '0;
      r_i_dv          <= 1'b0;
      r_i_err         <= 1'b0;
      r_i_data        <= '0;
      r_d_dv          <= 1'b0;
      r_d_err         <= 1'b0;
      r_d_data        <= '0;
    end else begin
      r_i_dv  <= 1'b0;
      r_i_err <= 1'b0;
      r_d_dv  <= 1'b0;
      r_d_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_port          <= w_pick;
            r_kill_inflight <= 1'b0;
            if (w_i_req && w_d_req) r_rr_last <= w_pick;
            if (w_addr_bad) begin
              if (w_pick == DTLB) begin
                r_d_dv   <= 1'b1;
                r_d_err  <= 1'b1;
                r_d_data <= '0;
              end else begin
                r_i_dv   <= 1'b1;
                r_i_err  <= 1'b1;
                r_i_data <= '0;
              end
            end else begin
              r_araddr  <= w_gnt_addr;
              r_arid    <= w_gnt_id;
              r_arvalid <= 1'b1;
              r_state   <= AR;
            end
          end
        end
        AR: begin
          if (w_port_kill) r_kill_inflight <= 1'b1;
          if (M_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= R;
          end
        end
        R: begin
          if (w_port_kill) r_kill_inflight <= 1'b1;
          if (M_RVALID) begin
            r_rready <= 1'b0;
            r_state  <= IDLE;
            if (!w_drop) begin
              if (r_port == DTLB) begin
                r_d_dv   <= 1'b1;
                r_d_err  <= w_rsp_err;
                r_d_data <= w_rsp_data;
              end else begin
                r_i_dv   <= 1'b1;
                r_i_err  <= w_rsp_err;
                r_i_data <= w_rsp_data;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ITLB_DATA_VALID = r_i_dv;
  assign ITLB_ERROR      = r_i_err;
  assign ITLB_DATA       = r_i_data;
  assign DTLB_DATA_VALID = r_d_dv;
  assign DTLB_ERROR      = r_d_err;
  assign DTLB_DATA       = r_d_data;
  assign M_ARVALID       = r_arvalid;
  assign M_ARADDR        = r_araddr;
  assign M_ARID          = r_arid;
  assign M_RREADY        = r_rready;
  assign M_ARLEN         = ARLEN_SINGLE;
  assign M_ARSIZE        = SIZE_8B;
  assign M_ARBURST       = BURST_INCR;
  assign M_ARPROT        = ARPROT_VAL;
  assign M_ARCACHE       = ARCACHE_VAL;

endmodule

// File: tb/tb_ptw_axi_reader.sv
// tb/tb_ptw_axi_reader.sv - scoreboard bench for ptw_axi_reader with a configurable AXI read slave
module tb_ptw_axi_reader;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        ITLB_ADDR_VALID, ITLB_KILL, DTLB_ADDR_VALID, DTLB_KILL;
  logic [63:0] ITLB_ADDR, DTLB_ADDR;
  logic        ITLB_DATA_VALID, ITLB_ERROR, DTLB_DATA_VALID, DTLB_ERROR;
  logic [63:0] ITLB_DATA, DTLB_DATA;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, M_RLAST;
  logic [63:0] M_ARADDR, M_RDATA;
  logic [3:0]  M_ARID, M_RID, M_ARCACHE;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE, M_ARPROT;
  logic [1:0]  M_ARBURST, M_RRESP;

  always #5 CLK = ~CLK;

  ptw_axi_reader dut (
    .CLK(CLK), .RSTN(RSTN),
    .ITLB_ADDR_VALID(ITLB_ADDR_VALID), .ITLB_ADDR(ITLB_ADDR), .ITLB_KILL(ITLB_KILL),
    .ITLB_DATA_VALID(ITLB_DATA_VALID), .ITLB_DATA(ITLB_DATA), .ITLB_ERROR(ITLB_ERROR),
    .DTLB_ADDR_VALID(DTLB_ADDR_VALID), .DTLB_ADDR(DTLB_ADDR), .DTLB_KILL(DTLB_KILL),
    .DTLB_DATA_VALID(DTLB_DATA_VALID), .DTLB_DATA(DTLB_DATA), .DTLB_ERROR(DTLB_ERROR),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARID(M_ARID),
    .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARPROT(M_ARPROT),
    .M_ARCACHE(M_ARCACHE), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
    .M_RID(M_RID), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  int n_pass = 0;
  int n_total = 0;
  exp_t q_i[$];
  exp_t q_d[$];
  logic [63:0] ar_addr_log[$];
  logic [3:0]  ar_id_log[$];
  int r_hs_cnt = 0;
  int arv_cnt = 0;
  int d_dv_cnt = 0;

  // Slave configuration, changed by the test tasks
  int          s_ar_stall = 0;
  int          s_r_stall = 0;
  logic        s_fix = 1'b0;
  logic [63:0] s_rdata = 64'h0;
  logic [1:0]  s_rresp = 2'b00;
  logic        s_rid_force = 1'b0;
  logic [3:0]  s_rid_val = 4'h0;
  logic        s_rlast = 1'b1;

  logic        pend = 1'b0;
  logic [63:0] pend_addr;
  logic [3:0]  pend_id;
  int          ar_wait = 0;
  int          r_wait = 0;

  function automatic logic [63:0] model_rdata(input logic [63:0] a);
    return a ^ 64'hC3C3_0000_5A5A_0000;
  endfunction

  // AXI read slave: decides ARREADY/RVALID mid-cycle for the next rising edge
  initial begin
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RID = '0; M_RRESP = '0; M_RLAST = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      if (!RSTN) begin
        pend = 1'b0; M_ARREADY = 1'b0; M_RVALID = 1'b0; ar_wait = 0; r_wait = 0;
      end else begin
        M_RVALID = 1'b0;
        if (pend && M_RREADY) begin
          if (r_wait < s_r_stall) r_wait++;
          else begin
            M_RVALID = 1'b1;
            M_RDATA  = s_fix ? s_rdata : model_rdata(pend_addr);
            M_RID    = s_rid_force ? s_rid_val : pend_id;
            M_RRESP  = s_rresp;
            M_RLAST  = s_rlast;
            pend = 1'b0; r_wait = 0; r_hs_cnt++;
          end
        end
        M_ARREADY = 1'b0;
        if (M_ARVALID) begin
          if (ar_wait < s_ar_stall) ar_wait++;
          else begin
            M_ARREADY = 1'b1;
            pend = 1'b1; pend_addr = M_ARADDR; pend_id = M_ARID; ar_wait = 0;
            ar_addr_log.push_back(M_ARADDR);
            ar_id_log.push_back(M_ARID);
          end
        end
      end
    end
  end

  // Response monitor: every DATA_VALID pops and checks the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (M_ARVALID) arv_cnt++;
      if (ITLB_DATA_VALID) begin
        n_total++;
        if (q_i.size() == 0)
          $display("FAIL itlb_unexpected: DATA_VALID with data=%h err=%b, none expected", ITLB_DATA, ITLB_ERROR);
        else begin
          e = q_i.pop_front();
          if (ITLB_DATA !== e.data || ITLB_ERROR !== e.err)
            $display("FAIL itlb_resp: got data=%h err=%b, want data=%h err=%b", ITLB_DATA, ITLB_ERROR, e.data, e.err);
          else n_pass++;
        end
      end
      if (DTLB_DATA_VALID) begin
        d_dv_cnt++;
        n_total++;
        if (q_d.size() == 0)
          $display("FAIL dtlb_unexpected: DATA_VALID with data=%h err=%b, none expected", DTLB_DATA, DTLB_ERROR);
        else begin
          e = q_d.pop_front();
          if (DTLB_DATA !== e.data || DTLB_ERROR !== e.err)
            $display("FAIL dtlb_resp: got data=%h err=%b, want data=%h err=%b", DTLB_DATA, DTLB_ERROR, e.data, e.err);
          else n_pass++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    RSTN = 1'b0;
    ITLB_ADDR_VALID = 1'b0; DTLB_ADDR_VALID = 1'b0; ITLB_KILL = 1'b0; DTLB_KILL = 1'b0;
    ITLB_ADDR = '0; DTLB_ADDR = '0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic send(input bit do_i, input logic [63:0] ai, input bit do_d, input logic [63:0] ad);
    @(negedge CLK);
    ITLB_ADDR_VALID = do_i; ITLB_ADDR = ai;
    DTLB_ADDR_VALID = do_d; DTLB_ADDR = ad;
    @(negedge CLK);
    ITLB_ADDR_VALID = 1'b0; DTLB_ADDR_VALID = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge CLK);
      #3;
      if (q_i.size() == 0 && q_d.size() == 0 && !M_ARVALID && !M_RREADY && !pend) break;
    end
    n_total++;
    if (k >= 300) $display("FAIL %s_drain: timeout with %0d itlb / %0d dtlb responses outstanding", tag, q_i.size(), q_d.size());
    else n_pass++;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    n_total++;
    if ({ITLB_DATA_VALID, ITLB_ERROR, DTLB_DATA_VALID, DTLB_ERROR, M_ARVALID, M_RREADY} !== 6'b0)
      $display("FAIL reset_ctrl: got %b, want 000000", {ITLB_DATA_VALID, ITLB_ERROR, DTLB_DATA_VALID, DTLB_ERROR, M_ARVALID, M_RREADY});
    else n_pass++;
    n_total++;
    if (ITLB_DATA !== 64'h0 || DTLB_DATA !== 64'h0 || M_ARADDR !== 64'h0 || M_ARID !== 4'h0)
      $display("FAIL reset_data: itlb=%h dtlb=%h araddr=%h arid=%h, want all 0", ITLB_DATA, DTLB_DATA, M_ARADDR, M_ARID);
    else n_pass++;
  endtask

  task automatic test_single();
    int base, lat;
    base = ar_addr_log.size();
    s_fix = 1'b1; s_rdata = 64'h2000_04CF;
    q_i.push_back({64'h2000_04CF, 1'b0});
    @(negedge CLK);
    ITLB_ADDR = 64'h0000_0080_0000_1238; ITLB_ADDR_VALID = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (k == 1) ITLB_ADDR_VALID = 1'b0;
      #3;
      if (ITLB_DATA_VALID) begin lat = k; break; end
    end
    n_total++;
    if (lat != 4) $display("FAIL single_latency: got %0d cycles, want 4", lat);
    else n_pass++;
    n_total++;
    if (ar_addr_log.size() != base + 1 || ar_addr_log[base] !== 64'h0000_0080_0000_1238 || ar_id_log[base] !== 4'd0)
      $display("FAIL single_ar: %0d new reads, first addr=%h id=%h, want 1 read addr=0000008000001238 id=0",
               ar_addr_log.size() - base, ar_addr_log[base], ar_id_log[base]);
    else n_pass++;
    n_total++;
    if ({M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT, M_ARCACHE} !== {8'd0, 3'd3, 2'b01, 3'b001, 4'b0011})
      $display("FAIL ar_consts: len=%h size=%h burst=%h prot=%h cache=%h, want 0/3/1/1/3",
               M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT, M_ARCACHE);
    else n_pass++;
    drain("single");
    s_fix = 1'b0;
  endtask

  task automatic test_round_robin();
    int base;
    logic [63:0] a_i1, a_d1, a_i2, a_d2;
    logic [3:0]  want_id [4];
    logic [63:0] want_ad [4];
    do_reset();
    base = ar_addr_log.size();
    a_i1 = 64'h0000_0000_1000_0010; a_d1 = 64'h0000_0000_2000_0025;
    a_i2 = 64'h0000_0012_3456_7008; a_d2 = 64'h0000_00AB_CDEF_0030;
    q_i.push_back({model_rdata(a_i1), 1'b0});
    q_d.push_back({model_rdata(a_d1 & ~64'h7), 1'b0});
    send(1'b1, a_i1, 1'b1, a_d1);
    drain("rr_pair1");
    q_d.push_back({model_rdata(a_d2), 1'b0});
    q_i.push_back({model_rdata(a_i2), 1'b0});
    send(1'b1, a_i2, 1'b1, a_d2);
    drain("rr_pair2");
    want_id = '{4'd0, 4'd1, 4'd1, 4'd0};
    want_ad = '{a_i1, a_d1 & ~64'h7, a_d2, a_i2};
    n_total++;
    if (ar_addr_log.size() != base + 4) $display("FAIL rr_count: got %0d reads, want 4", ar_addr_log.size() - base);
    else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_total++;
        if (ar_id_log[base+k] !== want_id[k] || ar_addr_log[base+k] !== want_ad[k])
          $display("FAIL rr_order%0d: got id=%h addr=%h, want id=%h addr=%h",
                   k, ar_id_log[base+k], ar_addr_log[base+k], want_id[k], want_ad[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bus_errors();
    s_rresp = 2'b10;
    q_d.push_back({64'h0, 1'b1});
    send(1'b0, 64'h0, 1'b1, 64'h0000_0000_0300_0040);
    drain("slverr");
    s_rresp = 2'b00;
    s_rid_force = 1'b1; s_rid_val = 4'd0;
    q_d.push_back({64'h0, 1'b1});
    send(1'b0, 64'h0, 1'b1, 64'h0000_0000_0300_0048);
    drain("bad_rid");
    s_rid_force = 1'b0;
    s_rlast = 1'b0;
    q_i.push_back({64'h0, 1'b1});
    send(1'b1, 64'h0000_0000_0300_0050, 1'b0, 64'h0);
    drain("no_rlast");
    s_rlast = 1'b1;
  endtask

  task automatic test_addr_error();
    int a0, base, lat;
    a0 = arv_cnt; base = ar_addr_log.size();
    q_d.push_back({64'h0, 1'b1});
    @(negedge CLK);
    DTLB_ADDR = 64'h0100_0000_0000_0000; DTLB_ADDR_VALID = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (k == 1) DTLB_ADDR_VALID = 1'b0;
      #3;
      if (DTLB_DATA_VALID) begin lat = k; break; end
    end
    n_total++;
    if (lat != 2) $display("FAIL addr_err_latency: got %0d cycles, want 2", lat);
    else n_pass++;
    drain("addr_err");
    n_total++;
    if (arv_cnt != a0 || ar_addr_log.size() != base)
      $display("FAIL addr_err_no_ar: got %0d ARVALID cycles, %0d reads, want 0/0", arv_cnt - a0, ar_addr_log.size() - base);
    else n_pass++;
  endtask

  task automatic test_kill_inflight();
    int a0, h0, d0, b0;
    s_ar_stall = 5;
    a0 = arv_cnt; h0 = r_hs_cnt; d0 = d_dv_cnt; b0 = ar_addr_log.size();
    @(negedge CLK);
    DTLB_ADDR = 64'h0000_0000_0040_2008; DTLB_ADDR_VALID = 1'b1;
    @(negedge CLK);
    DTLB_ADDR_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    DTLB_KILL = 1'b1;
    @(negedge CLK);
    DTLB_KILL = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      #3;
      if (r_hs_cnt > h0) break;
    end
    repeat (4) @(negedge CLK);
    s_ar_stall = 0;
    n_total++;
    if (arv_cnt - a0 != 6) $display("FAIL kill_arvalid_hold: got %0d ARVALID cycles, want 6", arv_cnt - a0);
    else n_pass++;
    n_total++;
    if (r_hs_cnt - h0 != 1 || ar_addr_log.size() - b0 != 1)
      $display("FAIL kill_beat: got %0d AR / %0d R handshakes, want 1/1", ar_addr_log.size() - b0, r_hs_cnt - h0);
    else n_pass++;
    n_total++;
    if (d_dv_cnt != d0) $display("FAIL kill_suppress: got %0d DTLB responses, want 0", d_dv_cnt - d0);
    else n_pass++;
    q_d.push_back({model_rdata(64'h0000_0000_0040_2010), 1'b0});
    send(1'b0, 64'h0, 1'b1, 64'h0000_0000_0040_2010);
    drain("after_kill");
  endtask

  task automatic test_reset_in_r();
    int a0, h0, k;
    s_r_stall = 3;
    h0 = r_hs_cnt;
    send(1'b1, 64'h0000_0000_0777_0000, 1'b0, 64'h0);
    for (k = 0; k < 20; k++) begin
      @(negedge CLK);
      #3;
      if (M_RREADY) break;
    end
    n_total++;
    if (k >= 20) $display("FAIL rst_reach_r: RREADY never rose, want high");
    else n_pass++;
    @(negedge CLK);
    DTLB_ADDR = 64'h0000_0000_0888_0000; DTLB_ADDR_VALID = 1'b1;
    @(negedge CLK);
    DTLB_ADDR_VALID = 1'b0;
    RSTN = 1'b0;
    @(negedge CLK);
    #3;
    n_total++;
    if ({M_RREADY, M_ARVALID, ITLB_DATA_VALID, DTLB_DATA_VALID, ITLB_ERROR, DTLB_ERROR} !== 6'b0 || M_ARADDR !== 64'h0)
      $display("FAIL rst_mid_r: ctrl=%b araddr=%h, want 000000 and 0",
               {M_RREADY, M_ARVALID, ITLB_DATA_VALID, DTLB_DATA_VALID, ITLB_ERROR, DTLB_ERROR}, M_ARADDR);
    else n_pass++;
    RSTN = 1'b1;
    s_r_stall = 0;
    a0 = arv_cnt;
    repeat (6) @(negedge CLK);
    n_total++;
    if (arv_cnt != a0 || r_hs_cnt != h0)
      $display("FAIL rst_slots_empty: got %0d ARVALID cycles, %0d R beats after reset, want 0/0", arv_cnt - a0, r_hs_cnt - h0);
    else n_pass++;
    q_i.push_back({model_rdata(64'h0000_0000_0999_0018), 1'b0});
    send(1'b1, 64'h0000_0000_0999_0018, 1'b0, 64'h0);
    drain("after_rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bus_errors();
    test_addr_error();
    test_kill_inflight();
    test_reset_in_r();
    repeat (4) @(negedge CLK);
    n_total++;
    if (q_i.size() != 0 || q_d.size() != 0)
      $display("FAIL final_scoreboard: %0d itlb / %0d dtlb responses never arrived, want 0/0", q_i.size(), q_d.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
